// File: rtl/sequence_monitor.sv
// -----------------------------------------------------------------------------
// sequence_monitor
//
// Downstream checker for the 4-bit JK-based sequence counter. A programmable
// table holds the expected count sequence. The monitor samples Q on every
// rising edge of C. It hunts for the first table entry and then tracks the
// sequence. It pulses err on each mismatch and counts completed periods
// (cycles) and mismatches (errors).
//
// Ports
//   C          in   clock; Q is sampled on the rising edge
//   R          in   synchronous active-high reset, highest priority
//   Q          in   W    count value from the counter
//   cfg_we     in   table write strobe
//   cfg_addr   in   4    table index
//   cfg_data   in   W    value written to table[cfg_addr]
//   cfg_len_we in   sequence-length write strobe
//   cfg_len    in   5    sequence length, clamped to DEPTH
//   state      out  2    0=IDLE, 1=HUNT, 2=TRACK (registered)
//   locked     out  high while state==TRACK (registered)
//   err        out  one-cycle pulse following a mismatching sample
//   cycles     out  8    completed sequence periods, wraps
//   errors     out  8    total mismatches, saturates at 255
// -----------------------------------------------------------------------------
module sequence_monitor #(
    parameter int W         = 4,
    parameter int DEPTH     = 16,
    parameter int ERR_LIMIT = 3
) (
    input  logic         C,
    input  logic         R,
    input  logic [W-1:0] Q,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         cfg_len_we,
    input  logic [4:0]   cfg_len,
    output logic [1:0]   state,
    output logic         locked,
    output logic         err,
    output logic [7:0]   cycles,
    output logic [7:0]   errors
);

    localparam int CW = $clog2(ERR_LIMIT + 1);
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);
    localparam logic [CW-1:0] LIMIT_L = CW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HUNT  = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_locked;
    logic          r_err;
    logic [7:0]    r_cycles;
    logic [7:0]    r_errors;
    logic [4:0]    r_len;
    logic [3:0]    r_ptr;
    logic [CW-1:0] r_consec;
    logic [W-1:0]  r_table [DEPTH];

    logic          w_addr_ok;
    logic [4:0]    w_len_clamped;
    logic          w_match;
    logic          w_ptr_last;
    logic [CW-1:0] w_consec_inc;

    assign w_addr_ok     = ({1'b0, cfg_addr} < DEPTH_L);
    assign w_len_clamped = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
    // Compares use the table contents before this edge's write.
    assign w_match       = (Q == r_table[r_ptr]);
    assign w_ptr_last    = ({1'b0, r_ptr} == (r_len - 5'd1));
    assign w_consec_inc  = r_consec + CW'(1);

    always_ff @(posedge C) begin
        if (R) begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_cycles <= 8'd0;
            r_errors <= 8'd0;
            r_len    <= 5'd0;
            r_ptr    <= 4'd0;
            r_consec <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_err <= 1'b0;
            if (cfg_we && w_addr_ok) begin
                r_table[cfg_addr] <= cfg_data;
            end
            if (cfg_len_we) begin
                // A length write restarts the search; the counters are kept.
                r_len    <= w_len_clamped;
                r_ptr    <= 4'd0;
                r_consec <= '0;
                r_locked <= 1'b0;
                r_state  <= (w_len_clamped == 5'd0) ? S_IDLE : S_HUNT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_locked <= 1'b0;
                    end
                    S_HUNT: begin
                        // r_ptr is 0 here, so w_match compares against table[0].
                        if (w_match) begin
                            r_state  <= S_TRACK;
                            r_locked <= 1'b1;
                            if (r_len > 5'd1) begin
                                r_ptr <= 4'd1;
                            end else begin
                                r_ptr    <= 4'd0;
                                r_cycles <= r_cycles + 8'd1;
                            end
                        end
                    end
                    S_TRACK: begin
                        // The period completes on the last entry even if it mismatched.
                        if (w_ptr_last) begin
                            r_ptr    <= 4'd0;
                            r_cycles <= r_cycles + 8'd1;
                        end else begin
                            r_ptr <= r_ptr + 4'd1;
                        end
                        if (w_match) begin
                            r_consec <= '0;
                        end else begin
                            r_err <= 1'b1;
                            if (r_errors != 8'hFF) begin
                                r_errors <= r_errors + 8'd1;
                            end
                            if (w_consec_inc == LIMIT_L) begin
                                r_state  <= S_HUNT;
                                r_locked <= 1'b0;
                                r_ptr    <= 4'd0;
                                r_consec <= '0;
                            end else begin
                                r_consec <= w_consec_inc;
                            end
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state  = r_state;
    assign locked = r_locked;
    assign err    = r_err;
    assign cycles = r_cycles;
    assign errors = r_errors;

endmodule

// File: tb/tb_sequence_monitor.sv
// -----------------------------------------------------------------------------
// tb_sequence_monitor
//
// Drives directed scenarios followed by a randomized phase. A behavioural
// model predicts the outputs after every edge and pushes them to exp_q. An
// independent monitor pops and compares 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_sequence_monitor;

    logic       C;
    logic       R;
    logic [3:0] Q;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       cfg_len_we;
    logic [4:0] cfg_len;
    logic [1:0] state;
    logic       locked;
    logic       err;
    logic [7:0] cycles;
    logic [7:0] errors;

    sequence_monitor dut (
        .C          (C),
        .R          (R),
        .Q          (Q),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .state      (state),
        .locked     (locked),
        .err        (err),
        .cycles     (cycles),
        .errors     (errors)
    );

    // ---------------- clock / reset ----------------
    initial C = 1'b0;
    always #5 C = ~C;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Mode follows the observable state numbering: 0 idle, 1 hunting, 2 tracking.
    int m_mode, m_len, m_pos, m_run, m_cycles, m_errors;
    bit m_err;
    int m_tab [16];

    logic [19:0] exp_q[$];
    int n_chk = 0;
    int n_err = 0;
    int n_pushed = 0;
    int n_popped = 0;

    task automatic model_step(input bit r, input bit we, input int addr, input int data,
                              input bit lwe, input int len_in, input int q);
        if (r) begin
            m_mode = 0; m_len = 0; m_pos = 0; m_run = 0;
            m_cycles = 0; m_errors = 0; m_err = 0;
            foreach (m_tab[i]) m_tab[i] = 0;
            return;
        end
        m_err = 0;
        if (lwe) begin
            m_len = (len_in > 16) ? 16 : len_in;
            m_pos = 0;
            m_run = 0;
            m_mode = (m_len == 0) ? 0 : 1;
        end else if (m_mode == 1) begin
            if (q == m_tab[0]) begin
                m_mode = 2;
                m_pos = 1 % m_len;
                if (m_pos == 0) m_cycles = (m_cycles + 1) % 256;
            end
        end else if (m_mode == 2) begin
            int want;
            want = m_tab[m_pos];
            m_pos = (m_pos + 1) % m_len;
            if (m_pos == 0) m_cycles = (m_cycles + 1) % 256;
            if (q == want) begin
                m_run = 0;
            end else begin
                m_err = 1;
                if (m_errors < 255) m_errors++;
                m_run++;
                if (m_run == 3) begin
                    m_mode = 1;
                    m_pos = 0;
                    m_run = 0;
                end
            end
        end
        if (we && addr < 16) m_tab[addr] = data;
    endtask

    function automatic logic [19:0] model_outputs();
        return {2'(m_mode), (m_mode == 2), m_err, 8'(m_cycles), 8'(m_errors)};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit r, input bit we, input int addr, input int data,
                         input bit lwe, input int len_in, input int q);
        @(negedge C);
        R = r; cfg_we = we; cfg_addr = 4'(addr); cfg_data = 4'(data);
        cfg_len_we = lwe; cfg_len = 5'(len_in); Q = 4'(q);
        @(posedge C);
        model_step(r, we, addr, data, lwe, len_in, q);
        exp_q.push_back(model_outputs());
        n_pushed++;
    endtask

    task automatic drive_q(input int q);
        drive(0, 0, 0, 0, 0, 0, q);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge C);
            #1;
            if (exp_q.size() > 0) begin
                logic [19:0] e;
                logic [19:0] a;
                e = exp_q.pop_front();
                n_popped++;
                a = {state, locked, err, cycles, errors};
                n_chk++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs @%0t: got state=%0d locked=%0d err=%0d cycles=%0d errors=%0d, want state=%0d locked=%0d err=%0d cycles=%0d errors=%0d",
                             $time, a[19:18], a[17], a[16], a[15:8], a[7:0],
                             e[19:18], e[17], e[16], e[15:8], e[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int seq4 [4] = '{3, 7, 2, 9};
    int stim_a [10] = '{5, 5, 3, 7, 2, 9, 3, 7, 2, 9};
    int stim_b [5] = '{3, 7, 4, 9, 3};

    initial begin
        R = 1'b1; Q = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_len_we = 1'b0; cfg_len = '0;

        // 1. reset with garbage on the other inputs, then idle edges
        for (int i = 0; i < 2; i++)
            drive(1, 1, $urandom_range(0, 15), $urandom_range(0, 15), 1,
                  $urandom_range(1, 31), $urandom_range(0, 15));
        for (int i = 0; i < 4; i++) drive_q($urandom_range(0, 15));

        // 2. load {3,7,2,9}, len=4, then lock and run two periods
        for (int i = 0; i < 4; i++) drive(0, 1, i, seq4[i], 0, 0, 0);
        drive(0, 0, 0, 0, 1, 4, 0);
        foreach (stim_a[i]) drive_q(stim_a[i]);

        // 3. single mismatch while locked
        foreach (stim_b[i]) drive_q(stim_b[i]);

        // 4. three consecutive mismatches drop lock, then re-lock on 3
        for (int i = 0; i < 3; i++) drive_q(0);
        drive_q(3);
        drive_q(7);

        // 5. len=1 with table[0]=F in the same edge; cycles wraps past 255
        drive(0, 1, 0, 15, 1, 1, 0);
        for (int i = 0; i < 300; i++) drive_q(15);
        // F re-locks, three zeros drop lock again: errors climbs to saturation
        for (int i = 0; i < 90; i++) begin
            drive_q(15);
            for (int k = 0; k < 3; k++) drive_q(0);
        end

        // 6. length write of 0 while tracking, then reset while tracking
        drive_q(15);
        drive_q(15);
        drive(0, 0, 0, 0, 1, 0, 15);
        drive_q(15);
        drive(0, 0, 0, 0, 1, 1, 15);
        drive_q(15);
        drive_q(15);
        drive(1, 0, 0, 0, 0, 0, 15);
        drive_q(15);

        // write to table then clamp: len beyond DEPTH
        drive(0, 1, 5, 2, 1, 31, 0);

        // 7. randomized traffic with a small alphabet so matches are common
        for (int i = 0; i < 2000; i++) begin
            bit r, we, lwe;
            int addr, data, len_in, q;
            r = ($urandom_range(0, 399) == 0);
            we = ($urandom_range(0, 7) == 0);
            addr = $urandom_range(0, 15);
            data = $urandom_range(0, 3);
            lwe = ($urandom_range(0, 59) == 0);
            len_in = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 6);
            if ($urandom_range(0, 2) != 0)
                q = (m_mode == 2) ? m_tab[m_pos] : m_tab[0];
            else
                q = $urandom_range(0, 3);
            drive(r, we, addr, data, lwe, len_in, q);
        end

        // drain and confirm every prediction was checked
        @(negedge C);
        @(negedge C);
        n_chk++;
        if (exp_q.size() != 0 || n_popped != n_pushed) begin
            n_err++;
            $display("FAIL drain: got pending=%0d popped=%0d, want pending=0 popped=%0d",
                     exp_q.size(), n_popped, n_pushed);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
